limn2600_xalu: RTL

LIMN2600_XALU -- requirements
Module: limn2600_xalu

---
 rtl/limn2600_alu_pkg.sv | 41 ++++
 rtl/limn2600_xalu_iter.sv | 93 +++++++++
 rtl/limn2600_xalu.sv | 126 ++++++++++++
 3 files changed

// File: rtl/limn2600_alu_pkg.sv
// Shared types for the limn2600 extended ALU.
// Holds the 4-bit operation encoding, the handshake FSM states and the
// helper that tells which operations go through the multi-cycle unit.
// Optional feature macro: LIMN2600_XALU_DIV_EN (iterative DIV/MOD).
package limn2600_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOR  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_SLTS = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_ADD  = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_SAR  = 4'b1010,
    OP_ROR  = 4'b1011,
    OP_MUL  = 4'b1100,
    OP_DIV  = 4'b1101,
    OP_MOD  = 4'b1110,
    OP_ILL  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Without the divider, DIV/MOD fall back to the single-cycle illegal path.
  function automatic logic is_iterative(input op_e op);
`ifdef LIMN2600_XALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/limn2600_xalu_iter.sv
// Radix-2 iterative unit: shift-add multiplier and, when
// LIMN2600_XALU_DIV_EN is defined, a restoring divider sharing the same
// three registers. The caller pulses start with the operands, then asserts
// step for exactly WIDTH cycles; result is then stable until the next start.
// Ports: clk, rst (sync, active-high), start, step, op (MUL/DIV/MOD select),
//        a, b (operands), result.
module limn2600_xalu_iter
  import limn2600_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // r_acc: product accumulator / partial remainder
  // r_opd: shifting multiplicand / divisor
  // r_sh : shifting multiplier / dividend-becoming-quotient
  logic [WIDTH-1:0] r_acc, r_opd, r_sh;
  logic [WIDTH-1:0] acc_nxt, opd_nxt, sh_nxt;

`ifdef LIMN2600_XALU_DIV_EN
  logic         div_mode, quo_sel;
  logic [WIDTH:0] rem_sh, trial;

  // Shift the next dividend bit into the remainder and try the subtract;
  // a clear top bit means the divisor fitted. With b = 0 every trial fits,
  // giving an all-ones quotient and a remainder equal to a.
  assign rem_sh = {r_acc, r_sh[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, r_opd};
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    acc_nxt = r_sh[0] ? (r_acc + r_opd) : r_acc;
    opd_nxt = r_opd << 1;
    sh_nxt  = r_sh >> 1;
`ifdef LIMN2600_XALU_DIV_EN
    if (div_mode) begin
      opd_nxt = r_opd;
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, so c reads 0 after reset.
    if (rst) begin
      r_acc <= '0;
      r_opd <= '0;
      r_sh  <= '0;
`ifdef LIMN2600_XALU_DIV_EN
      div_mode <= 1'b0;
      quo_sel  <= 1'b0;
`endif
    end else if (start) begin
      r_acc <= '0;
`ifdef LIMN2600_XALU_DIV_EN
      div_mode <= (op == OP_DIV) || (op == OP_MOD);
      quo_sel  <= (op == OP_DIV);
      r_opd    <= (op == OP_MUL) ? a : b;
      r_sh     <= (op == OP_MUL) ? b : a;
`else
      r_opd <= (op == OP_MUL) ? a : '0;
      r_sh  <= (op == OP_MUL) ? b : '0;
`endif
    end else if (step) begin
      r_acc <= acc_nxt;
      r_opd <= opd_nxt;
      r_sh  <= sh_nxt;
    end
  end

`ifdef LIMN2600_XALU_DIV_EN
  assign result = quo_sel ? r_sh : r_acc;
`else
  assign result = r_acc;
`endif

endmodule

// File: rtl/limn2600_xalu.sv
// limn2600 extended ALU with valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after acceptance; MUL (and DIV/MOD
// when LIMN2600_XALU_DIV_EN is defined) run WIDTH radix-2 steps in
// limn2600_xalu_iter. A finished result is held until out_ready, and a new
// request may be accepted on the same edge the old one retires.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, op[3:0], a, b,
//        out_valid/out_ready, c (result), err (illegal or disabled op).
module limn2600_xalu
  import limn2600_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [SH_W-1:0]  cnt;
  logic [WIDTH-1:0] c_q, alu_c, iter_res;
  logic             err_q, alu_err, sel_iter;
  logic             accept, iter_op;
  op_e              op_in;
  logic [SH_W-1:0]  shamt;
  logic [SH_W:0]    rot_left;

  assign op_in    = op_e'(op);
  assign iter_op  = is_iterative(op_in);
  assign accept   = in_valid & in_ready;
  assign shamt    = b[SH_W-1:0];
  assign rot_left = (SH_W + 1)'(WIDTH) - {1'b0, shamt};

  // Handshake FSM: next state and both ready/valid flags.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = iter_op ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = iter_op ? ST_BUSY : ST_DONE;
          else          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle datapath. Iterative ops land in the default arm too, but
  // their alu_c/alu_err are never captured.
  always_comb begin
    alu_c   = '0;
    alu_err = 1'b0;
    case (op_in)
      OP_ADD:  alu_c = a + b;
      OP_SUB:  alu_c = a - b;
      OP_AND:  alu_c = a & b;
      OP_XOR:  alu_c = a ^ b;
      OP_OR:   alu_c = a | b;
      OP_NOR:  alu_c = ~(a | b);
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLTS: alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  alu_c = a << shamt;
      OP_SHR:  alu_c = a >> shamt;
      OP_SAR:  alu_c = $signed(a) >>> shamt;
      // Left part shifts by WIDTH when shamt is 0, which yields zero.
      OP_ROR:  alu_c = (a >> shamt) | (a << rot_left);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
      sel_iter <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel_iter <= iter_op;
        c_q      <= iter_op ? '0 : alu_c;
        err_q    <= iter_op ? 1'b0 : alu_err;
        cnt      <= iter_op ? SH_W'(WIDTH - 1) : '0;
      end else if (state == ST_BUSY && cnt != '0) begin
        cnt <= cnt - SH_W'(1);
      end
    end
  end

  // Steps on every BUSY edge: WIDTH edges from cnt = WIDTH-1 down to 0.
  limn2600_xalu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept & iter_op),
    .step   (state == ST_BUSY),
    .op     (op_in),
    .a      (a),
    .b      (b),
    .result (iter_res)
  );

  assign c   = sel_iter ? iter_res : c_q;
  assign err = err_q;

endmodule
